// File: rtl/neuron_mac.sv
// Single-neuron MAC: streams activations against a weight ROM, adds bias, saturates to DATA_WIDTH.
// Optional ReLU on the result when RELU_EN is defined; the default build is a linear activation.
module neuron_mac #(
  parameter int                           NUM_WEIGHT = 30,
  parameter int                           DATA_WIDTH = 16,
  parameter int                           FRAC_BITS  = 12,
  parameter int                           ADDR_WIDTH = $clog2(NUM_WEIGHT),
  parameter logic signed [DATA_WIDTH-1:0] BIAS       = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  w_ren,
  output logic [ADDR_WIDTH-1:0] w_radd,
  input  logic [DATA_WIDTH-1:0] w_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);

  localparam int ACC_W = 2*DATA_WIDTH + ADDR_WIDTH;
  localparam int SUM_W = ACC_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_WEIGHT - 1);

  typedef enum logic [1:0] {S_ACCUM, S_DRAIN, S_FINAL, S_OUT} state_t;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [ADDR_WIDTH-1:0]         r_count;
  logic signed [DATA_WIDTH-1:0]  r_x_d;
  logic                          r_pipe_v;
  logic signed [ACC_W-1:0]       r_acc;
  logic                          r_out_valid;
  logic [DATA_WIDTH-1:0]         r_out_data;

  logic                          w_hs;
  logic                          w_out_hs;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [SUM_W-1:0]       w_bias_ext;
  logic signed [SUM_W-1:0]       w_sum;
  logic signed [SUM_W-1:0]       w_shift;
  logic [SUM_W-DATA_WIDTH:0]     w_hi;
  logic [DATA_WIDTH-1:0]         w_sat;
  logic [DATA_WIDTH-1:0]         w_res;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    case (r_state)
      S_ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && (r_count == LAST)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: w_state_nxt = S_FINAL;
      S_FINAL: w_state_nxt = S_OUT;
      S_OUT:   if (r_out_valid && out_ready) w_state_nxt = S_ACCUM;
      default: w_state_nxt = S_ACCUM;
    endcase
  end

  assign w_hs      = in_valid & in_ready;
  assign w_out_hs  = r_out_valid & out_ready;
  assign w_ren     = w_hs;
  assign w_radd    = r_count;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  assign w_prod     = r_x_d * $signed(w_in);
  assign w_bias_ext = {{(SUM_W-DATA_WIDTH){BIAS[DATA_WIDTH-1]}}, BIAS} << FRAC_BITS;
  assign w_sum      = {r_acc[ACC_W-1], r_acc} + w_bias_ext;
  assign w_shift    = w_sum >>> FRAC_BITS;
  assign w_hi       = w_shift[SUM_W-1:DATA_WIDTH-1];

  // Fits in DATA_WIDTH only when every bit above the result sign bit copies it.
  always_comb begin
    w_sat = w_shift[DATA_WIDTH-1:0];
    if (!((&w_hi) || (~|w_hi))) begin
      if (w_hi[SUM_W-DATA_WIDTH]) w_sat = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else                        w_sat = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

`ifdef RELU_EN
  assign w_res = w_sat[DATA_WIDTH-1] ? '0 : w_sat;
`else
  assign w_res = w_sat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_ACCUM;
      r_count     <= '0;
      r_x_d       <= '0;
      r_pipe_v    <= 1'b0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pipe_v <= w_hs;
      if (w_hs) begin
        r_x_d   <= $signed(in_data);
        r_count <= r_count + 1'b1;
      end
      if (w_out_hs) begin
        r_acc       <= '0;
        r_count     <= '0;
        r_out_valid <= 1'b0;
      end else if (r_pipe_v) begin
        r_acc <= r_acc + {{ADDR_WIDTH{w_prod[2*DATA_WIDTH-1]}}, w_prod};
      end
      if (r_state == S_FINAL) begin
        r_out_data  <= w_res;
        r_out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: table of uniform activation/weight evaluations with a result scoreboard,
// an address-sequence monitor, and hand-written reset / latency / backpressure sequences.
module tb_neuron_mac;

  localparam int NW = 30;
  localparam int DW = 16;
  localparam int AW = 5;

`ifdef RELU_EN
  localparam logic [DW-1:0] NEG_MIN  = 16'h0000;
  localparam logic [DW-1:0] NEG_F100 = 16'h0000;
  localparam logic [DW-1:0] NEG_FFFF = 16'h0000;
`else
  localparam logic [DW-1:0] NEG_MIN  = 16'h8000;
  localparam logic [DW-1:0] NEG_F100 = 16'hF100;
  localparam logic [DW-1:0] NEG_FFFF = 16'hFFFF;
`endif

  typedef struct {
    logic [DW-1:0] x;
    logic [DW-1:0] w;
    logic [DW-1:0] exp0;
    logic [DW-1:0] exp1;
    bit            gaps;
    int unsigned   hold;
  } vec_t;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          in_valid  = 1'b0;
  logic [DW-1:0] in_data   = '0;
  logic          out_ready = 1'b1;

  logic          in_ready0, w_ren0, out_valid0;
  logic [AW-1:0] w_radd0;
  logic [DW-1:0] w_in0 = '0;
  logic [DW-1:0] out_data0;
  logic          in_ready1, w_ren1, out_valid1;
  logic [AW-1:0] w_radd1;
  logic [DW-1:0] w_in1 = '0;
  logic [DW-1:0] out_data1;

  logic [DW-1:0] rom_w = '0;
  logic [DW-1:0] exp_q[$];
  int unsigned   n_vec = 0;
  int unsigned   n_bad = 0;
  int unsigned   exp_addr = 0;
  vec_t          tbl[8];

  always #5 clk = ~clk;

  neuron_mac #(.NUM_WEIGHT(NW), .DATA_WIDTH(DW), .FRAC_BITS(12)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .w_ren(w_ren0), .w_radd(w_radd0), .w_in(w_in0),
    .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready)
  );

  neuron_mac #(.NUM_WEIGHT(NW), .DATA_WIDTH(DW), .FRAC_BITS(12), .BIAS(16'sh1000)) u_dut_bias (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .w_ren(w_ren1), .w_radd(w_radd1), .w_in(w_in1),
    .out_valid(out_valid1), .out_data(out_data1), .out_ready(out_ready)
  );

  // Weight ROM models: one-cycle read latency, uniform contents per evaluation.
  always @(posedge clk) begin
    if (w_ren0) w_in0 <= rom_w;
    if (w_ren1) w_in1 <= rom_w;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Every accepted activation must read the next ROM address in order.
  always @(negedge clk) begin
    if (rst_n && w_ren1) chk("w_radd_bias", 32'(w_radd1), exp_addr);
    if (rst_n && w_ren0) begin
      chk("w_radd", 32'(w_radd0), exp_addr);
      exp_addr++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [DW-1:0] x, input int unsigned n, input bit gaps);
    for (int unsigned i = 0; i < n; i++) begin
      if (gaps) begin
        int unsigned g;
        g = $urandom_range(0, 2);
        in_valid = 1'b0;
        repeat (g) begin
          in_data = 16'($urandom);
          tick();
        end
      end
      in_valid = 1'b1;
      in_data  = x;
      tick();
    end
  endtask

  task automatic run_eval(input vec_t v);
    logic [DW-1:0] e;
    rom_w     = v.w;
    out_ready = (v.hold == 0);
    feed(v.x, NW, v.gaps);
    exp_q.push_back(v.exp0);
    in_data = 16'h7FFF;
    @(negedge clk);
    chk("drain_out_valid", 32'(out_valid0), 0);
    chk("drain_in_ready", 32'(in_ready0), 0);
    chk("drain_w_ren", 32'(w_ren0), 0);
    tick();
    @(negedge clk);
    chk("final_out_valid", 32'(out_valid0), 0);
    tick();
    @(negedge clk);
    chk("latency_out_valid", 32'(out_valid0), 1);
    chk("latency_out_valid_bias", 32'(out_valid1), 1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else                   e = 'x;
    chk("out_data", 32'(out_data0), 32'(e));
    chk("out_data_bias", 32'(out_data1), 32'(v.exp1));
    for (int unsigned k = 0; k < v.hold; k++) begin
      tick();
      @(negedge clk);
      chk("hold_out_valid", 32'(out_valid0), 1);
      chk("hold_out_data", 32'(out_data0), 32'(e));
      chk("hold_in_ready", 32'(in_ready0), 0);
      chk("hold_w_ren", 32'(w_ren0), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("post_out_valid", 32'(out_valid0), 0);
    chk("post_in_ready", 32'(in_ready0), 1);
    chk("post_in_ready_bias", 32'(in_ready1), 1);
    chk("addr_count", exp_addr, NW);
    exp_addr = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{x:16'h0100, w:16'h0800, exp0:16'h0F00, exp1:16'h1F00, gaps:1'b0, hold:0};
    tbl[1] = '{x:16'h7FFF, w:16'h7FFF, exp0:16'h7FFF, exp1:16'h7FFF, gaps:1'b0, hold:0};
    tbl[2] = '{x:16'h7FFF, w:16'h8000, exp0:NEG_MIN,  exp1:NEG_MIN,  gaps:1'b0, hold:0};
    tbl[3] = '{x:16'h0000, w:16'h1234, exp0:16'h0000, exp1:16'h1000, gaps:1'b0, hold:0};
    tbl[4] = '{x:16'hFF00, w:16'h0800, exp0:NEG_F100, exp1:16'h0100, gaps:1'b0, hold:0};
    tbl[5] = '{x:16'hFFFF, w:16'h0001, exp0:NEG_FFFF, exp1:16'h0FFF, gaps:1'b0, hold:0};
    tbl[6] = '{x:16'h0001, w:16'h0001, exp0:16'h0000, exp1:16'h1000, gaps:1'b1, hold:3};
    tbl[7] = '{x:16'h0100, w:16'h0800, exp0:16'h0F00, exp1:16'h1F00, gaps:1'b1, hold:10};

    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready0), 1);
    chk("reset_w_ren", 32'(w_ren0), 0);
    chk("reset_out_valid", 32'(out_valid0), 0);
    chk("reset_out_data", 32'(out_data0), 0);
    chk("reset_w_radd", 32'(w_radd0), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Abort an evaluation after 10 inputs; the partial sum must not leak into the next one.
    rom_w = 16'h0800;
    feed(16'h0100, 10, 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid0), 0);
    chk("midrst_w_ren", 32'(w_ren0), 0);
    chk("midrst_in_ready", 32'(in_ready0), 1);
    chk("midrst_addr_count", exp_addr, 10);
    exp_addr = 0;
    tick();
    rst_n = 1'b1;
    tick();

    for (int unsigned i = 0; i < 8; i++) run_eval(tbl[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
